audio_pwm_dac: RTL and testbench

- Downstream consumer of the audio stream that the radio user design drives out of its audio output port.
- Buffers 32-bit stb/ack audio words in a small FIFO and paces them out at a fixed sample rate.
- Converts each word to a 1-bit PWM waveform for the Nexys 4 mono audio amplifier, plus an amplifier-enable pin and a sticky underrun flag.

---
 rtl/audio_pwm_dac_if.sv | 25 ++
 rtl/audio_pwm_dac.sv | 140 ++++++++++++++
 tb/tb_audio_pwm_dac.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pwm_dac_if.sv
// ============================================================================
// audio_pwm_dac_if : stb/ack audio word stream feeding audio_pwm_dac
// Rev 1.0
// ============================================================================
`default_nettype none

interface audio_pwm_dac_if;
   logic [31:0] input_audio;
   logic        input_audio_stb;
   logic        input_audio_ack;

   modport master (
      output input_audio,
      output input_audio_stb,
      input  input_audio_ack
   );

   modport slave (
      input  input_audio,
      input  input_audio_stb,
      output input_audio_ack
   );
endinterface

`default_nettype wire

// File: rtl/audio_pwm_dac.sv
// ============================================================================
// audio_pwm_dac : FIFO-buffered, rate-paced PWM audio DAC for a mono amplifier.
// Optional macro AUDIO_PWM_SIGMA_DELTA_EN swaps the comparator for sigma-delta.
// Rev 1.0
// ============================================================================
`default_nettype none

module audio_pwm_dac #(
   parameter int SAMPLE_DIV = 2048,
   parameter int PWM_BITS   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic                        clk,
   input  wire logic                        rst,
   audio_pwm_dac_if.slave                   audio_in,
   input  wire logic                        clear_underrun,
   output logic                             audio_pwm,
   output logic                             audio_sd,
   output logic                             underrun,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

   localparam int                  AW       = $clog2(FIFO_DEPTH);
   localparam int                  LW       = AW + 1;
   localparam logic [LW-1:0]       LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [15:0]         TICK_AT  = 16'(SAMPLE_DIV - 1);
   localparam logic [PWM_BITS-1:0] MID      = {1'b1, {(PWM_BITS-1){1'b0}}};
   localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

   logic [PWM_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]       level_q, level_d;
   logic                ack_q, sd_q, underrun_q;
   logic [15:0]         scnt_q;
   logic [PWM_BITS-1:0] pcnt_q, pending_q, duty_q;

   logic [15:0]         w_flip;
   logic [PWM_BITS-1:0] w_conv;
   logic                w_push, w_tick, w_empty, w_pop;
   logic                w_unused;

   // Offset-binary conversion: flipping the sign bit maps -32768..32767 onto 0..65535.
   assign w_flip   = audio_in.input_audio[15:0] ^ 16'h8000;
   assign w_conv   = w_flip[15 -: PWM_BITS];
   assign w_unused = ^{audio_in.input_audio[31:16], w_flip[15-PWM_BITS:0]};

   assign w_push  = audio_in.input_audio_stb & ack_q;
   assign w_tick  = (scnt_q == TICK_AT);
   assign w_empty = (level_q == '0);
   assign w_pop   = w_tick & ~w_empty;

   always_comb begin
      level_d = level_q;
      if (w_push && !w_pop) begin
         level_d = level_q + LW'(1);
      end else if (w_pop && !w_push) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= w_conv;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ack_q      <= 1'b0;
         sd_q       <= 1'b0;
         underrun_q <= 1'b0;
         scnt_q     <= '0;
         pcnt_q     <= '0;
         pending_q  <= MID;
         duty_q     <= MID;
      end else begin
         level_q <= level_d;
         // Ack looks at the post-update level so a full FIFO never sees another write.
         ack_q   <= (level_d != LVL_FULL);
         sd_q    <= 1'b1;
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (w_pop) begin
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            pending_q <= mem_q[rd_ptr_q];
         end
         scnt_q <= w_tick ? '0 : scnt_q + 16'd1;
         if (w_tick && w_empty) begin
            underrun_q <= 1'b1;
         end else if (clear_underrun) begin
            underrun_q <= 1'b0;
         end
         pcnt_q <= pcnt_q + PWM_BITS'(1);
         if (pcnt_q == PWM_MAX) begin
            duty_q <= pending_q;
         end
      end
   end

`ifdef AUDIO_PWM_SIGMA_DELTA_EN
   // Top bit of the accumulator register is the registered carry that drives the pin.
   logic [PWM_BITS:0] acc_q, acc_sum;

   assign acc_sum = {1'b0, acc_q[PWM_BITS-1:0]} + {1'b0, duty_q};

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_sum;
      end
   end

   assign audio_pwm = acc_q[PWM_BITS];
`else
   logic pwm_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= (pcnt_q < duty_q);
      end
   end

   assign audio_pwm = pwm_q;
`endif

   assign audio_in.input_audio_ack = ack_q;
   assign audio_sd                 = sd_q;
   assign underrun                 = underrun_q;
   assign fifo_level               = level_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_pwm_dac.sv
// ============================================================================
// tb_audio_pwm_dac : scoreboarded bench for audio_pwm_dac (PWM_BITS=8,
// SAMPLE_DIV=512, FIFO_DEPTH=4). Rev 1.0
// ============================================================================
`default_nettype none

module tb_audio_pwm_dac;
   localparam int SAMPLE_DIV = 512;
   localparam int PWM_BITS   = 8;
   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clear_underrun = 1'b0;
   logic       audio_pwm, audio_sd, underrun;
   logic [2:0] fifo_level;

   audio_pwm_dac_if bus ();

   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          exp_q[$];

   audio_pwm_dac #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .PWM_BITS   (PWM_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .audio_in       (bus.slave),
      .clear_underrun (clear_underrun),
      .audio_pwm      (audio_pwm),
      .audio_sd       (audio_sd),
      .underrun       (underrun),
      .fifo_level     (fifo_level)
   );

   always #5 clk = ~clk;

   // Edges since reset release; both DUT counters start at 0 with this count.
   always @(posedge clk) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.input_audio_stb = 1'b0;
      bus.input_audio = 32'h0;
      clear_underrun = 1'b0;
      exp_q.delete();
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_cyc(input int unsigned target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic push_word(input logic [31:0] word, output bit ok);
      ok = 1'b0;
      bus.input_audio = word;
      bus.input_audio_stb = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.input_audio_ack === 1'b1) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.input_audio_stb = 1'b0;
   endtask

   // Counts highs over the 256 outputs following edge `start` (one duty epoch).
   task automatic measure(input int unsigned start, output int cnt);
      cnt = 0;
      wait_cyc(start);
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (audio_pwm === 1'b1) cnt++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.input_audio = 32'h0000_1234;
      bus.input_audio_stb = 1'b1;
      repeat (5) @(negedge clk);
      n_tests++; if (bus.input_audio_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.input_audio_ack); end
      n_tests++; if (audio_pwm !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", audio_pwm); end
      n_tests++; if (audio_sd !== 1'b0) begin n_fail++; $display("FAIL reset_sd: got %b want 0", audio_sd); end
      n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      rst = 1'b1;
      @(negedge clk);
      bus.input_audio_stb = 1'b0;
      n_tests++; if (audio_sd !== 1'b1) begin n_fail++; $display("FAIL release_sd: got %b want 1", audio_sd); end
      n_tests++; if (bus.input_audio_ack !== 1'b1) begin n_fail++; $display("FAIL release_ack: got %b want 1", bus.input_audio_ack); end
      @(negedge clk);
      n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL release_no_push: got level %0d want 0", fifo_level); end
   endtask

   task automatic test_conversion();
      logic [31:0] words [4] = '{32'h0000_0000, 32'h0000_8000, 32'h0000_7FFF, 32'hABCD_0000};
      int          duty  [4] = '{128, 0, 255, 128};
      bit ok;
      int cnt;
      for (int k = 0; k < 4; k++) begin
         do_reset();
         exp_q.push_back(duty[k]);
         push_word(words[k], ok);
         n_tests++; if (!ok) begin n_fail++; $display("FAIL conv_push[%0d]: not accepted within 20 cycles", k); end
         measure(768, cnt);
         n_tests++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL conv_sb[%0d]: scoreboard empty, got %0d", k, cnt); end
         else begin
            int e = exp_q.pop_front();
            if (cnt !== e) begin n_fail++; $display("FAIL conv[%0d] word %h: high count %0d want %0d", k, words[k], cnt, e); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [5] = '{32'h0000_0000, 32'h0000_4000, 32'h0000_C000, 32'h0000_7FFF, 32'h0000_8000};
      int          duty  [5] = '{128, 192, 64, 255, 0};
      int idx = 0;
      int guard = 0;
      bit found = 1'b0;
      int cnt;
      do_reset();
      while (idx < 4 && guard < 20) begin
         bus.input_audio = words[idx];
         bus.input_audio_stb = 1'b1;
         if (bus.input_audio_ack === 1'b1) begin
            exp_q.push_back(duty[idx]);
            idx++;
         end
         @(negedge clk);
         guard++;
      end
      bus.input_audio = words[4];
      n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d want 4", fifo_level); end
      n_tests++; if (bus.input_audio_ack !== 1'b0) begin n_fail++; $display("FAIL full_ack: got %b want 0", bus.input_audio_ack); end
      for (int i = 0; i < 700; i++) begin
         if (fifo_level === 3'd3) begin found = 1'b1; break; end
         @(negedge clk);
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL drain_level: level never reached 3, got %0d", fifo_level); end
      n_tests++; if (bus.input_audio_ack !== 1'b1) begin n_fail++; $display("FAIL drain_ack: got %b want 1", bus.input_audio_ack); end
      exp_q.push_back(duty[4]);
      @(negedge clk);
      bus.input_audio_stb = 1'b0;
      n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fifth_push_level: got %0d want 4", fifo_level); end
      for (int k = 0; k < 5; k++) begin
         measure(768 + 512 * k, cnt);
         n_tests++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb[%0d]: scoreboard empty, got %0d", k, cnt); end
         else begin
            int e = exp_q.pop_front();
            if (cnt !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: high count %0d want %0d", k, cnt, e); end
         end
      end
   endtask

   task automatic test_underrun();
      int cnt;
      do_reset();
      exp_q.push_back(128);
      wait_cyc(511);
      n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_pre_tick: got %b want 0", underrun); end
      wait_cyc(512);
      n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_first_tick: got %b want 1", underrun); end
      measure(1024, cnt);
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL underrun_sb: scoreboard empty, got %0d", cnt); end
      else begin
         int e = exp_q.pop_front();
         if (cnt !== e) begin n_fail++; $display("FAIL underrun_duty: high count %0d want %0d", cnt, e); end
      end
      n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
      wait_cyc(1300);
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
      n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b want 0", underrun); end
      wait_cyc(1535);
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
      n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set_wins: got %b want 1", underrun); end
   endtask

   task automatic test_glitch_free();
      bit ok;
      int cnt;
      do_reset();
      exp_q.push_back(128);
      exp_q.push_back(128);
      exp_q.push_back(192);
      exp_q.push_back(192);
      push_word(32'h0000_4000, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL glitch_push: not accepted within 20 cycles"); end
      for (int k = 0; k < 4; k++) begin
         measure(256 + 256 * k, cnt);
         n_tests++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL glitch_sb[%0d]: scoreboard empty, got %0d", k, cnt); end
         else begin
            int e = exp_q.pop_front();
            if (cnt !== e) begin n_fail++; $display("FAIL glitch_period[%0d]: high count %0d want %0d", k, cnt, e); end
         end
      end
   endtask

`ifdef AUDIO_PWM_SIGMA_DELTA_EN
   task automatic test_sigma_delta();
      bit   ok;
      int   cnt;
      logic prev;
      do_reset();
      exp_q.push_back(128);
      push_word(32'h0000_0000, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL sd_push: not accepted within 20 cycles"); end
      wait_cyc(800);
      prev = audio_pwm;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_tests++; if (audio_pwm === prev) begin n_fail++; $display("FAIL sd_alternate[%0d]: got %b after %b", i, audio_pwm, prev); end
         prev = audio_pwm;
      end
      measure(1024, cnt);
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL sd_sb: scoreboard empty, got %0d", cnt); end
      else begin
         int e = exp_q.pop_front();
         if (cnt !== e) begin n_fail++; $display("FAIL sd_density: high count %0d want %0d", cnt, e); end
      end
   endtask
`endif

   initial begin
      bus.input_audio = 32'h0;
      bus.input_audio_stb = 1'b0;
      test_reset();
      test_conversion();
      test_back_to_back();
      test_underrun();
      test_glitch_free();
`ifdef AUDIO_PWM_SIGMA_DELTA_EN
      test_sigma_delta();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
